// File: rtl/p18_pixel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : p18_pixel_arbiter
//  Description : Per-pixel priority compositor (ball > paddle > border >
//                bricks > background) with a frame-synchronous border-flash
//                sequencer. Colour and winning layer ID are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module p18_pixel_arbiter #(
  parameter logic [5:0] BG_COLOR      = 6'b000000,
  parameter logic [5:0] FLASH_COLOR   = 6'b000011,
  parameter int         FLASH_PERIOD  = 4,
  parameter int         FLASH_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       video_active,
  input  logic       frame_tick,
  input  logic       flash_req,
  input  logic       border_in,
  input  logic [5:0] border_color,
  input  logic       bricks_in,
  input  logic [5:0] bricks_color,
  input  logic       paddle_in,
  input  logic [5:0] paddle_color,
  input  logic       ball_in,
  input  logic [5:0] ball_color,
  output logic [5:0] rgb,
  output logic [2:0] layer,
  output logic       flash_busy
);

  localparam int FC_W = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam int TG_W = $clog2(FLASH_TOGGLES + 1);

  localparam logic [FC_W-1:0] C_FC_LAST = FC_W'(FLASH_PERIOD - 1);
  localparam logic [TG_W-1:0] C_TG_INIT = TG_W'(FLASH_TOGGLES);
  localparam logic [TG_W-1:0] C_TG_ONE  = TG_W'(1);

  localparam logic [2:0] C_LAYER_BG     = 3'd0;
  localparam logic [2:0] C_LAYER_BRICKS = 3'd1;
  localparam logic [2:0] C_LAYER_BORDER = 3'd2;
  localparam logic [2:0] C_LAYER_PADDLE = 3'd3;
  localparam logic [2:0] C_LAYER_BALL   = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FLASH_ON  = 2'd1,
    S_FLASH_OFF = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            pending_q, pending_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [TG_W-1:0] toggles_left_q, toggles_left_d;
  logic [5:0]      rgb_q, rgb_d;
  logic [2:0]      layer_q, layer_d;
  logic [5:0]      border_eff;

  // Flash sequencer: a pending request restarts the sequence on the next
  // frame tick; otherwise ticks count frames and alternate the phase.
  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    toggles_left_d = toggles_left_q;
    pending_d      = pending_q | flash_req;
    if (frame_tick) begin
      if (pending_q) begin
        state_d        = S_FLASH_ON;
        frame_cnt_d    = '0;
        toggles_left_d = C_TG_INIT;
        // A request arriving in the consuming tick cycle stays pending.
        pending_d      = flash_req;
      end else if (state_q != S_IDLE) begin
        if (frame_cnt_q == C_FC_LAST) begin
          frame_cnt_d = '0;
          if (toggles_left_q == C_TG_ONE) begin
            state_d = S_IDLE;
          end else begin
            state_d        = (state_q == S_FLASH_ON) ? S_FLASH_OFF : S_FLASH_ON;
            toggles_left_d = toggles_left_q - C_TG_ONE;
          end
        end else begin
          frame_cnt_d = frame_cnt_q + FC_W'(1);
        end
      end
    end
  end

  // Priority compositor; the border colour is overridden during FLASH_ON
  // using the state as it stands before this cycle's tick takes effect.
  always_comb begin
    border_eff = (state_q == S_FLASH_ON) ? FLASH_COLOR : border_color;
    rgb_d      = BG_COLOR;
    layer_d    = C_LAYER_BG;
    if (!video_active) begin
      rgb_d   = 6'd0;
      layer_d = C_LAYER_BG;
    end else if (ball_in) begin
      rgb_d   = ball_color;
      layer_d = C_LAYER_BALL;
    end else if (paddle_in) begin
      rgb_d   = paddle_color;
      layer_d = C_LAYER_PADDLE;
    end else if (border_in) begin
      rgb_d   = border_eff;
      layer_d = C_LAYER_BORDER;
    end else if (bricks_in) begin
      rgb_d   = bricks_color;
      layer_d = C_LAYER_BRICKS;
    end
  end

  // State, counters and pixel output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pending_q      <= 1'b0;
      frame_cnt_q    <= '0;
      toggles_left_q <= '0;
      rgb_q          <= 6'd0;
      layer_q        <= C_LAYER_BG;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      frame_cnt_q    <= frame_cnt_d;
      toggles_left_q <= toggles_left_d;
      rgb_q          <= rgb_d;
      layer_q        <= layer_d;
    end
  end

  assign rgb        = rgb_q;
  assign layer      = layer_q;
  assign flash_busy = pending_q | (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_p18_pixel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_p18_pixel_arbiter
//  Description : Self-checking bench for p18_pixel_arbiter with a frame-level
//                reference model (flash timeline counted in whole frames).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_p18_pixel_arbiter;

  localparam logic [5:0] BG_COLOR      = 6'b000000;
  localparam logic [5:0] FLASH_COLOR   = 6'b000011;
  localparam int         FLASH_PERIOD  = 4;
  localparam int         FLASH_TOGGLES = 6;

  logic       clk = 1'b0;
  logic       rst_n, video_active, frame_tick, flash_req;
  logic       border_in, bricks_in, paddle_in, ball_in;
  logic [5:0] border_color, bricks_color, paddle_color, ball_color;
  logic [5:0] rgb;
  logic [2:0] layer;
  logic       flash_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a flash is a run of PERIOD*TOGGLES frames, ON in even
  // PERIOD-sized chunks counted from the starting tick.
  bit         m_pending, m_active;
  int         m_frames;
  logic [5:0] exp_rgb;
  logic [2:0] exp_layer;
  logic       exp_busy;

  p18_pixel_arbiter #(
    .BG_COLOR(BG_COLOR), .FLASH_COLOR(FLASH_COLOR),
    .FLASH_PERIOD(FLASH_PERIOD), .FLASH_TOGGLES(FLASH_TOGGLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .video_active(video_active),
    .frame_tick(frame_tick), .flash_req(flash_req),
    .border_in(border_in), .border_color(border_color),
    .bricks_in(bricks_in), .bricks_color(bricks_color),
    .paddle_in(paddle_in), .paddle_color(paddle_color),
    .ball_in(ball_in), .ball_color(ball_color),
    .rgb(rgb), .layer(layer), .flash_busy(flash_busy)
  );

  always #5 clk = ~clk;

  // Advance one clock: predict outputs from pre-edge inputs, update model.
  task automatic clk_step();
    bit on_phase;
    bit new_pending;
    on_phase = m_active && (((m_frames / FLASH_PERIOD) % 2) == 0);
    if (!rst_n || !video_active) begin exp_rgb = 6'd0; exp_layer = 3'd0; end
    else if (ball_in)   begin exp_rgb = ball_color;   exp_layer = 3'd4; end
    else if (paddle_in) begin exp_rgb = paddle_color; exp_layer = 3'd3; end
    else if (border_in) begin exp_rgb = on_phase ? FLASH_COLOR : border_color; exp_layer = 3'd2; end
    else if (bricks_in) begin exp_rgb = bricks_color; exp_layer = 3'd1; end
    else                begin exp_rgb = BG_COLOR;     exp_layer = 3'd0; end
    if (!rst_n) begin
      m_pending = 0; m_active = 0; m_frames = 0;
    end else begin
      new_pending = flash_req ? 1'b1 : (frame_tick ? 1'b0 : m_pending);
      if (frame_tick) begin
        if (m_pending) begin
          m_active = 1; m_frames = 0;
        end else if (m_active) begin
          m_frames++;
          if (m_frames == FLASH_PERIOD * FLASH_TOGGLES) m_active = 0;
        end
      end
      m_pending = new_pending;
    end
    exp_busy = m_pending | m_active;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pix();
    video_active = ($urandom_range(0, 7) != 0);
    border_in    = ($urandom_range(0, 3) != 0);
    bricks_in    = $urandom_range(0, 1);
    paddle_in    = ($urandom_range(0, 3) == 0);
    ball_in      = ($urandom_range(0, 4) == 0);
    border_color = 6'($urandom);
    bricks_color = 6'($urandom);
    paddle_color = 6'($urandom);
    ball_color   = 6'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 0; video_active = 1; frame_tick = 1; flash_req = 1;
    border_in = 1; bricks_in = 1; paddle_in = 1; ball_in = 1;
    border_color = 6'h3F; bricks_color = 6'h21; paddle_color = 6'h30; ball_color = 6'h0C;
    clk_step();
    n_checks++;
    if ({rgb, layer, flash_busy} !== {6'd0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: rgb/layer/busy got %h/%0d/%b want 00/0/0", rgb, layer, flash_busy);
    end
    clk_step();
    rst_n = 1; frame_tick = 0; flash_req = 0;
    clk_step();
  endtask

  task automatic test_priority();
    logic [3:0] claims [6];
    logic [5:0] want_rgb [6];
    logic [2:0] want_layer [6];
    claims = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1111};
    want_rgb = '{6'h0C, 6'h30, 6'h3F, 6'h21, BG_COLOR, 6'h00};
    want_layer = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    border_color = 6'h3F; ball_color = 6'h0C; paddle_color = 6'h30; bricks_color = 6'h21;
    for (int i = 0; i < 6; i++) begin
      {ball_in, paddle_in, border_in, bricks_in} = claims[i];
      video_active = (i != 5);
      clk_step();
      n_checks++;
      if ({rgb, layer} !== {want_rgb[i], want_layer[i]} || {rgb, layer} !== {exp_rgb, exp_layer}) begin
        n_fail++;
        $display("FAIL priority[%0d]: rgb/layer got %h/%0d want %h/%0d", i, rgb, layer, want_rgb[i], want_layer[i]);
      end
    end
  endtask

  task automatic test_full_flash();
    flash_req = 1; rand_pix(); clk_step(); flash_req = 0;
    n_checks++;
    if (flash_busy !== 1'b1) begin
      n_fail++; $display("FAIL flash_busy_rise: got %b want 1", flash_busy);
    end
    for (int f = 0; f < 26; f++) begin
      for (int c = 0; c < 4; c++) begin
        frame_tick = (c == 0); rand_pix();
        if (c == 2) begin video_active = 1; ball_in = 0; paddle_in = 0; border_in = 1; end
        clk_step();
        n_checks++;
        if ({rgb, layer, flash_busy} !== {exp_rgb, exp_layer, exp_busy}) begin
          n_fail++;
          $display("FAIL full_flash f%0d c%0d: rgb/layer/busy got %h/%0d/%b want %h/%0d/%b",
                   f, c, rgb, layer, flash_busy, exp_rgb, exp_layer, exp_busy);
        end
      end
    end
    frame_tick = 0;
    n_checks++;
    if (flash_busy !== 1'b0) begin
      n_fail++; $display("FAIL flash_done: busy got %b want 0", flash_busy);
    end
  endtask

  task automatic test_retrigger();
    for (int f = 0; f < 38; f++) begin
      for (int c = 0; c < 3; c++) begin
        frame_tick = (c == 0);
        flash_req  = (c == 1) && (f == 0 || f == 11);
        rand_pix();
        clk_step();
        n_checks++;
        if ({rgb, layer, flash_busy} !== {exp_rgb, exp_layer, exp_busy}) begin
          n_fail++;
          $display("FAIL retrigger f%0d c%0d: rgb/layer/busy got %h/%0d/%b want %h/%0d/%b",
                   f, c, rgb, layer, flash_busy, exp_rgb, exp_layer, exp_busy);
        end
      end
    end
    frame_tick = 0; flash_req = 0;
  endtask

  task automatic test_same_cycle();
    flash_req = 1; frame_tick = 1; rand_pix(); clk_step();
    flash_req = 0;
    n_checks++;
    if (flash_busy !== 1'b1 || exp_busy !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_busy: got %b want 1", flash_busy);
    end
    for (int f = 0; f < 6; f++) begin
      for (int c = 0; c < 3; c++) begin
        frame_tick = (c == 2); rand_pix();
        video_active = 1; ball_in = 0; paddle_in = 0; border_in = 1; border_color = 6'h3C;
        clk_step();
        n_checks++;
        if ({rgb, layer, flash_busy} !== {exp_rgb, exp_layer, exp_busy}) begin
          n_fail++;
          $display("FAIL same_cycle f%0d c%0d: rgb/layer/busy got %h/%0d/%b want %h/%0d/%b",
                   f, c, rgb, layer, flash_busy, exp_rgb, exp_layer, exp_busy);
        end
      end
    end
    frame_tick = 0;
  endtask

  task automatic test_midflash_reset();
    for (int f = 0; f < 6; f++) begin
      for (int c = 0; c < 3; c++) begin
        frame_tick = (c == 0); flash_req = (f == 0 && c == 1);
        rst_n = !(f == 3 && c == 1);
        if (f == 3 && c == 1) flash_req = 1;
        rand_pix();
        video_active = 1; ball_in = 0; paddle_in = 0; border_in = 1;
        clk_step();
        n_checks++;
        if ({rgb, layer, flash_busy} !== {exp_rgb, exp_layer, exp_busy}) begin
          n_fail++;
          $display("FAIL midflash_reset f%0d c%0d: rgb/layer/busy got %h/%0d/%b want %h/%0d/%b",
                   f, c, rgb, layer, flash_busy, exp_rgb, exp_layer, exp_busy);
        end
      end
    end
    rst_n = 1; frame_tick = 0; flash_req = 0;
    n_checks++;
    if (flash_busy !== 1'b0) begin
      n_fail++; $display("FAIL midflash_reset_idle: busy got %b want 0", flash_busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      frame_tick = ($urandom_range(0, 5) == 0);
      flash_req  = ($urandom_range(0, 60) == 0);
      rst_n      = ($urandom_range(0, 400) != 0);
      rand_pix();
      clk_step();
      n_checks++;
      if ({rgb, layer, flash_busy} !== {exp_rgb, exp_layer, exp_busy}) begin
        n_fail++;
        $display("FAIL random i%0d: rgb/layer/busy got %h/%0d/%b want %h/%0d/%b",
                 i, rgb, layer, flash_busy, exp_rgb, exp_layer, exp_busy);
      end
    end
    rst_n = 1; frame_tick = 0; flash_req = 0;
  endtask

  initial begin
    m_pending = 0; m_active = 0; m_frames = 0;
    test_reset();
    test_priority();
    test_full_flash();
    test_retrigger();
    test_same_cycle();
    test_midflash_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
